// File: rtl/enable_pacer_pkg.sv
// enable_pacer shared definitions
// FSM encodings and gap-counter sizing
package enable_pacer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam int GAP_W = 8;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    HOLDOFF = ST_HOLDOFF
  } state_e;

  // Reload value for the gap counter after an ISSUE cycle
  function automatic logic [GAP_W-1:0] gap_load(input int gap);
    if (gap > 0) begin
      return GAP_W'(gap - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/enable_pacer_counter.sv
// enable_pacer backlog counter
// Saturating up/down counter with sync clear
module sat_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign sat   = (count_q == MAX);
  assign count = count_q;

  // Next count: clear wins, inc+dec cancel, clamp at both ends
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && !sat) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/enable_pacer.sv
// enable_pacer top
// Paces queued requests into spaced enable pulses
module enable_pacer
  import enable_pacer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             ready_in,
  input  logic             clear,
  output logic             enable_out,
  output logic [WIDTH-1:0] pending,
  output logic             overflow,
  output logic             busy
);

  localparam logic [GAP_W-1:0] GAP_LD = gap_load(GAP);

  state_e           state_q;
  state_e           state_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  logic             en_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             sat;
  logic             issue;

  assign issue = (state_q == ISSUE);

  sat_updown_counter #(
    .WIDTH (WIDTH)
  ) u_backlog (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick_in),
    .dec   (issue),
    .clr   (clear),
    .count (pending),
    .sat   (sat)
  );

  // A tick is lost only when full and not offset by an issue
  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (tick_in && sat && !issue) begin
      ovf_d = 1'b1;
    end
  end

  // Next state and gap counter; clear overrides everything
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (clear) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if ((pending != '0) && ready_in) begin
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (GAP > 0) begin
            state_d = HOLDOFF;
            gap_d   = GAP_LD;
          end else begin
            state_d = IDLE;
          end
        end
        HOLDOFF: begin
          if (gap_q == '0) begin
            state_d = IDLE;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  // State, gap, pulse and sticky flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      en_q    <= (state_d == ISSUE);
      ovf_q   <= ovf_d;
    end
  end

  assign enable_out = en_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE) || (pending != '0);

endmodule

// File: tb/tb_enable_pacer.sv
// enable_pacer testbench
// Vector table, corner sequences, random vs model
module tb_enable_pacer;

  localparam int WIDTH = 4;
  localparam int GAP   = 2;
  localparam int MAXP  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             tick;
  logic             ready;
  logic             clr;
  logic             en;
  logic [WIDTH-1:0] pend;
  logic             ovf;
  logic             bsy;

  int checks;
  int failures;

  // reference model: pulse spacing from the last issue time
  int cyc;
  int m_pend;
  bit m_ovf;
  bit m_en;
  bit have_last;
  int last;

  enable_pacer #(
    .WIDTH (WIDTH),
    .GAP   (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick),
    .ready_in   (ready),
    .clear      (clr),
    .enable_out (en),
    .pending    (pend),
    .overflow   (ovf),
    .busy       (bsy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    return !m_en && (!have_last || (cyc >= last + GAP + 1));
  endfunction

  function automatic bit m_busy();
    return (m_pend > 0) || !m_idle();
  endfunction

  task automatic model_reset();
    m_pend    = 0;
    m_ovf     = 0;
    m_en      = 0;
    have_last = 0;
  endtask

  task automatic model_edge(input bit t, input bit r, input bit c);
    bit en_n;
    int p;
    en_n = 0;
    p    = m_pend;
    if (c) begin
      p         = 0;
      m_ovf     = 0;
      have_last = 0;
    end else begin
      en_n = m_idle() && (m_pend > 0) && r;
      if (m_en) begin
        if (!t) p = m_pend - 1;
      end else if (t) begin
        if (m_pend == MAXP) m_ovf = 1;
        else p = m_pend + 1;
      end
    end
    cyc++;
    m_pend = p;
    m_en   = en_n;
    if (en_n) begin
      have_last = 1;
      last      = cyc;
    end
  endtask

  task automatic cmp_model();
    chk("m_enable", int'(en), int'(m_en));
    chk("m_pending", int'(pend), m_pend);
    chk("m_overflow", int'(ovf), int'(m_ovf));
    chk("m_busy", int'(bsy), int'(m_busy()));
  endtask

  task automatic step(input bit t, input bit r, input bit c);
    tick  = t;
    ready = r;
    clr   = c;
    model_edge(t, r, c);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    bit t;
    bit r;
    bit c;
    bit en;
    int pend;
    bit ovf;
    bit busy;
  } vec_t;

  vec_t vt[12];

  initial begin
    int npulse;
    int pulses[$];
    int fall;
    int thr;

    checks   = 0;
    failures = 0;
    cyc      = 0;
    last     = 0;
    model_reset();

    vt[0]  = '{1, 1, 0, 0, 1, 0, 1};
    vt[1]  = '{0, 1, 0, 1, 1, 0, 1};
    vt[2]  = '{0, 1, 0, 0, 0, 0, 1};
    vt[3]  = '{0, 1, 0, 0, 0, 0, 1};
    vt[4]  = '{0, 1, 0, 0, 0, 0, 0};
    vt[5]  = '{1, 0, 0, 0, 1, 0, 1};
    vt[6]  = '{1, 0, 0, 0, 2, 0, 1};
    vt[7]  = '{1, 1, 0, 1, 3, 0, 1};
    vt[8]  = '{1, 1, 0, 0, 3, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 3, 0, 1};
    vt[10] = '{0, 0, 0, 0, 3, 0, 1};
    vt[11] = '{1, 1, 1, 0, 0, 0, 0};

    rst   = 1'b0;
    tick  = 1'b0;
    ready = 1'b0;
    clr   = 1'b0;

    // held in reset with random requests
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      tick  = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      chk("rst_enable", int'(en), 0);
      chk("rst_pending", int'(pend), 0);
      chk("rst_overflow", int'(ovf), 0);
      chk("rst_busy", int'(bsy), 0);
    end
    tick = 1'b0;
    rst  = 1'b1;
    model_reset();

    // table: latency, coincident tick at issue, clear
    for (int i = 0; i < 12; i++) begin
      step(vt[i].t, vt[i].r, vt[i].c);
      chk($sformatf("vec%0d_en", i), int'(en), int'(vt[i].en));
      chk($sformatf("vec%0d_pend", i), int'(pend), vt[i].pend);
      chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vt[i].ovf));
      chk($sformatf("vec%0d_busy", i), int'(bsy), int'(vt[i].busy));
    end

    // five back-to-back ticks
    for (int i = 0; i < 40; i++) begin
      step(i < 5, 1'b1, 1'b0);
      if (en) pulses.push_back(i);
    end
    chk("burst_count", pulses.size(), 5);
    for (int i = 1; i < pulses.size(); i++) begin
      chk("burst_spacing", pulses[i] - pulses[i-1], GAP + 2);
    end
    chk("burst_ovf", int'(ovf), 0);
    chk("burst_idle", int'(bsy), 0);

    // busy falls right after the last holdoff
    pulses.delete();
    fall = -1;
    for (int i = 0; i < 40; i++) begin
      step(i < 5, 1'b1, 1'b0);
      if (en) pulses.push_back(i);
      if (fall < 0 && i > 5 && !bsy) fall = i;
    end
    if (pulses.size() == 5) chk("busy_fall", fall, pulses[4] + GAP + 1);
    else chk("busy_fall_pulses", pulses.size(), 5);

    // overflow with ready low, then drain
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0);
    chk("sat_pending", int'(pend), MAXP);
    chk("sat_ovf", int'(ovf), 1);
    npulse = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (en) npulse++;
    end
    chk("drain_pulses", npulse, MAXP);
    chk("drain_pending", int'(pend), 0);
    chk("drain_ovf", int'(ovf), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_ovf", int'(ovf), 0);

    // async reset mid-holdoff with pending=4
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("pre_issue", int'(en), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("holdoff_pend", int'(pend), 4);
    chk("holdoff_busy", int'(bsy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_en", int'(en), 0);
    chk("async_pend", int'(pend), 0);
    chk("async_ovf", int'(ovf), 0);
    chk("async_busy", int'(bsy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // clear mid-burst
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("mid_issue", int'(en), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clear_pend", int'(pend), 0);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (en) npulse++;
    end
    chk("clear_pulses", npulse, 0);

    // random traffic against the model
    thr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: thr = 15;
          1: thr = 50;
          default: thr = 90;
        endcase
      end
      step($urandom_range(0, 99) < thr,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 127) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
